// File: rtl/jstk_pkg.sv
// Shared constants, state encoding and frame builder for the PmodJSTK SPI-slave emulator.
package jstk_pkg;

    localparam int DEF_FRAME_BYTES = 5;
    localparam int FRAME_BITS      = 40;
    localparam int LED_CMD_BIT     = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } jstk_state_e;

    // Byte order on the wire: X lo, X hi, Y lo, Y hi, buttons; MSB of each byte first.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] btn
    );
        return {x[7:0], 6'b000000, x[9:8], y[7:0], 6'b000000, y[9:8], 5'b00000, btn};
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous SPI pin with rise/fall pulses on the synced copy.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // synchroniser chain plus one cycle of history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign rise = sync_r[STAGES-1] & ~prev_r;
    assign fall = ~sync_r[STAGES-1] & prev_r;

endmodule

// File: rtl/jstk_spi_slave.sv
// PmodJSTK SPI-slave emulator: serves X/Y/BTN frames, captures the command byte to drive LED.
// Optional FRAME_ERR abort pulse is built when JSTK_FRAME_ERR_EN is defined.
module jstk_spi_slave
    import jstk_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BYTES = DEF_FRAME_BYTES
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] X_POS,
    input  logic [9:0] Y_POS,
    input  logic [2:0] BTN,
    input  logic       SS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    output logic [1:0] LED,
    output logic [7:0] CMD_BYTE,
    output logic       FRAME_DONE
`ifdef JSTK_FRAME_ERR_EN
    ,
    output logic       FRAME_ERR
`endif
);

    localparam int FBITS = 8 * FRAME_BYTES;
    localparam int CW    = $clog2(FBITS + 1);

    logic                   ss_rise_s, ss_fall_s, sclk_rise_s, sclk_fall_s;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   mosi_s;
    logic [FBITS-1:0]       load_s;
    jstk_state_e            state_r, next_state_s;
    logic                   start_s, shift_in_s, shift_out_s, finish_s;
    logic                   armed_r, miso_r, frame_done_r;
    logic [CW-1:0]          bit_cnt_r;
    logic [FBITS-1:0]       tx_r;
    logic [7:0]             rx_r, cmd_r, cmd_byte_r;
    logic [1:0]             led_r;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk(CLK), .rst(RST), .din(SS), .rise(ss_rise_s), .fall(ss_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(CLK), .rst(RST), .din(SCLK), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    // MOSI needs no edges, only the same delay as SCLK so data lines up with the rise pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            mosi_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
        end
    end

    assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
    // Frame left-aligned into the shift register: zero-padded or truncated to FBITS.
    assign load_s = FBITS'({build_frame(X_POS, Y_POS, BTN), {FBITS{1'b0}}} >> FRAME_BITS);

    // state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // next-state and datapath strobes
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        shift_in_s   = 1'b0;
        shift_out_s  = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (ss_fall_s && armed_r) begin
                    next_state_s = SHIFT;
                    start_s      = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (ss_rise_s) begin
                    next_state_s = IDLE;
                end else if (sclk_rise_s) begin
                    shift_in_s = 1'b1;
                    if (bit_cnt_r == CW'(FBITS - 1)) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = SHIFT;
                    end
                end else if (sclk_fall_s) begin
                    shift_out_s  = 1'b1;
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            DONE: begin
                if (ss_rise_s) begin
                    next_state_s = IDLE;
                    finish_s     = 1'b1;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // shift registers, bit counter, MISO and the frame-completion outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            armed_r      <= 1'b0;
            miso_r       <= 1'b0;
            bit_cnt_r    <= {CW{1'b0}};
            tx_r         <= {FBITS{1'b0}};
            rx_r         <= 8'h00;
            cmd_r        <= 8'h00;
            cmd_byte_r   <= 8'h00;
            led_r        <= 2'b00;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= finish_s;
            // synced SS starts low after reset, so its first high level shows up as a rise
            if (ss_rise_s) armed_r <= 1'b1;
            if (start_s) begin
                tx_r      <= load_s;
                miso_r    <= load_s[FBITS-1];
                bit_cnt_r <= {CW{1'b0}};
                rx_r      <= 8'h00;
            end else if (shift_out_s) begin
                tx_r   <= tx_r << 1;
                miso_r <= tx_r[FBITS-2];
            end else if (next_state_s != SHIFT) begin
                miso_r <= 1'b0;
            end
            if (shift_in_s) begin
                rx_r      <= {rx_r[6:0], mosi_s};
                bit_cnt_r <= bit_cnt_r + CW'(1);
                if (bit_cnt_r == CW'(7)) cmd_r <= {rx_r[6:0], mosi_s};
            end
            if (finish_s) begin
                cmd_byte_r <= cmd_r;
                if (cmd_r[LED_CMD_BIT]) led_r <= cmd_r[1:0];
            end
        end
    end

`ifdef JSTK_FRAME_ERR_EN
    logic frame_err_r;

    // any SS rise while still shifting is an aborted frame
    always_ff @(posedge CLK) begin
        if (RST) begin
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= (state_r == SHIFT) && ss_rise_s;
        end
    end

    assign FRAME_ERR = frame_err_r;
`endif

    assign MISO       = miso_r;
    assign LED        = led_r;
    assign CMD_BYTE   = cmd_byte_r;
    assign FRAME_DONE = frame_done_r;

endmodule

// File: tb/tb_jstk_spi_slave.sv
// Directed bench for jstk_spi_slave: table of full/over-long/aborted frames plus X-change and reset sequences.
module tb_jstk_spi_slave;

    localparam int HALF = 10;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [9:0] X_POS = 10'd0;
    logic [9:0] Y_POS = 10'd0;
    logic [2:0] BTN = 3'd0;
    logic       SS = 1'b1;
    logic       SCLK = 1'b0;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [1:0] LED;
    logic [7:0] CMD_BYTE;
    logic       FRAME_DONE;
`ifdef JSTK_FRAME_ERR_EN
    logic       FRAME_ERR;
`endif

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    jstk_spi_slave dut (
        .CLK(CLK), .RST(RST), .X_POS(X_POS), .Y_POS(Y_POS), .BTN(BTN),
        .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .LED(LED),
        .CMD_BYTE(CMD_BYTE), .FRAME_DONE(FRAME_DONE)
`ifdef JSTK_FRAME_ERR_EN
        , .FRAME_ERR(FRAME_ERR)
`endif
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (FRAME_DONE === 1'b1) done_cnt++;
`ifdef JSTK_FRAME_ERR_EN
        if (FRAME_ERR === 1'b1) err_cnt++;
`endif
    end

    typedef struct {
        int          nbits;
        logic [7:0]  cmd;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  btn;
        logic [63:0] exp_rx;
        logic [1:0]  exp_led;
        logic [7:0]  exp_cmd;
        int          exp_done;
        int          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // One SS-low window of nbits mode-0 SCLK cycles; optional X change / reset at a given bit.
    task automatic run_frame(input int nbits, input logic [7:0] cmd, input int chg_bit,
                             input logic [9:0] chg_x, input int rst_bit, output logic [63:0] rx);
        rx = 64'd0;
        SS = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) X_POS = chg_x;
            if (i == rst_bit) begin
                RST = 1'b1;
                wait_clk(3);
                RST = 1'b0;
                wait_clk(1);
                check("rst_mid_miso", {63'd0, MISO}, 64'd0);
                check("rst_mid_led", {62'd0, LED}, 64'd0);
                check("rst_mid_cmd", {56'd0, CMD_BYTE}, 64'd0);
            end
            MOSI = (i < 8) ? cmd[7-i] : 1'b0;
            wait_clk(HALF);
            rx = {rx[62:0], MISO};
            SCLK = 1'b1;
            wait_clk(HALF);
            SCLK = 1'b0;
        end
        wait_clk(HALF);
        SS = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic frame_checks(input string tag, input int nbits, input logic [7:0] cmd,
                                input int chg_bit, input logic [9:0] chg_x, input int rst_bit,
                                input logic [63:0] exp_rx, input logic [1:0] exp_led,
                                input logic [7:0] exp_cmd, input int exp_done, input int exp_err);
        logic [63:0] rx;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        run_frame(nbits, cmd, chg_bit, chg_x, rst_bit, rx);
        check({tag, "_rx"}, rx, exp_rx);
        check({tag, "_led"}, {62'd0, LED}, {62'd0, exp_led});
        check({tag, "_cmd"}, {56'd0, CMD_BYTE}, {56'd0, exp_cmd});
        check({tag, "_done"}, 64'(done_cnt - d0), 64'(exp_done));
        check({tag, "_idle_miso"}, {63'd0, MISO}, 64'd0);
`ifdef JSTK_FRAME_ERR_EN
        check({tag, "_err"}, 64'(err_cnt - e0), 64'(exp_err));
`else
        if (exp_err < 0) $display("unexpected error expectation %0d (e0=%0d)", exp_err, e0);
`endif
    endtask

    initial begin
        vecs[0] = '{40, 8'h83, 10'h2A5, 10'h15A, 3'b101, 64'h000000A5025A0105, 2'b11, 8'h83, 1, 0};
        vecs[1] = '{40, 8'h02, 10'h2A5, 10'h15A, 3'b101, 64'h000000A5025A0105, 2'b11, 8'h02, 1, 0};
        vecs[2] = '{40, 8'h81, 10'h000, 10'h3FF, 3'b010, 64'h000000000000FF0302, 2'b01, 8'h81, 1, 0};
        vecs[3] = '{40, 8'h00, 10'h155, 10'h0AA, 3'b111, 64'h0000005501AA0007, 2'b01, 8'h00, 1, 0};
        vecs[4] = '{48, 8'h82, 10'h2A5, 10'h15A, 3'b101, 64'h0000A5025A010500, 2'b10, 8'h82, 1, 0};
        vecs[5] = '{20, 8'h81, 10'h2A5, 10'h15A, 3'b101, 64'h00000000000A5025, 2'b10, 8'h82, 0, 1};

        wait_clk(5);
        check("reset_miso", {63'd0, MISO}, 64'd0);
        check("reset_led", {62'd0, LED}, 64'd0);
        check("reset_cmd", {56'd0, CMD_BYTE}, 64'd0);
        check("reset_done", {63'd0, FRAME_DONE}, 64'd0);
        RST = 1'b0;
        wait_clk(HALF);

        for (int k = 0; k < 6; k++) begin
            X_POS = vecs[k].x;
            Y_POS = vecs[k].y;
            BTN   = vecs[k].btn;
            frame_checks($sformatf("v%0d", k), vecs[k].nbits, vecs[k].cmd, -1, 10'd0, -1,
                         vecs[k].exp_rx, vecs[k].exp_led, vecs[k].exp_cmd,
                         vecs[k].exp_done, vecs[k].exp_err);
        end

        // X changes after 12 bits: current frame keeps the snapshot, next frame sees the new value
        X_POS = 10'h2A5; Y_POS = 10'h15A; BTN = 3'b101;
        frame_checks("xchg_a", 40, 8'h01, 12, 10'h3FF, -1, 64'h000000A5025A0105, 2'b10, 8'h01, 1, 0);
        frame_checks("xchg_b", 40, 8'h81, -1, 10'd0, -1, 64'h000000FF035A0105, 2'b01, 8'h81, 1, 0);

        // reset with SS low after 20 bits: rest of the window ignored, next frame normal
        X_POS = 10'h2A5;
        frame_checks("rst_a", 40, 8'h82, -1, 10'd0, 20, 64'h000000A502500000, 2'b00, 8'h00, 0, 0);
        frame_checks("rst_b", 40, 8'h83, -1, 10'd0, -1, 64'h000000A5025A0105, 2'b11, 8'h83, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
